// File: rtl/scene_draw_sequencer_pkg.sv
// Shared types and image-ROM layout constants for the scene draw sequencer.
// ROM addresses and screen positions are ints; users truncate them to their port widths.
package scene_draw_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT} seq_state_t;
  typedef logic [3:0] slot_t;

  localparam int NUM_SLOTS = 10;
  localparam slot_t SLOT_CURSOR = 4'd0;
  localparam slot_t SLOT_ENEMY1 = 4'd1;
  localparam slot_t SLOT_ENEMY2 = 4'd2;
  localparam slot_t SLOT_ENEMY3 = 4'd3;
  localparam slot_t SLOT_BASE1  = 4'd4;
  localparam slot_t SLOT_BASE2  = 4'd5;
  localparam slot_t SLOT_BASE3  = 4'd6;
  localparam slot_t SLOT_HUND   = 4'd7;
  localparam slot_t SLOT_TENS   = 4'd8;
  localparam slot_t SLOT_UNITS  = 4'd9;

  localparam int ADR_CURSOR     = 'h0100;
  localparam int ADR_BASE_OK    = 'h0200;
  localparam int ADR_BASE_NUKED = 'h0240;
  localparam int ADR_DIGIT0     = 'h0400;
  localparam int DIGIT_STRIDE   = 'h0040;

  localparam int X_BASE1 = 48;
  localparam int X_BASE2 = 128;
  localparam int X_BASE3 = 208;
  localparam int Y_BASE  = 232;

  function automatic int digit_offset(input logic [3:0] digit);
    return ADR_DIGIT0 + int'(digit) * DIGIT_STRIDE;
  endfunction

  function automatic int x_base(input logic [1:0] idx);
    case (idx)
      2'd0:    return X_BASE1;
      2'd1:    return X_BASE2;
      default: return X_BASE3;
    endcase
  endfunction

endpackage

// File: rtl/bcd_converter.sv
// Iterative double-dabble: one binary bit per cycle, OUT_WIDTH cycles after i_start.
// Only three BCD digits are kept, which covers every value of an 8-bit input.
module bcd_converter #(
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [OUT_WIDTH-1:0] i_bin,
  output logic                 o_done,
  output logic [3:0]           o_hundreds,
  output logic [3:0]           o_tens,
  output logic [3:0]           o_units
);

  localparam int CW = $clog2(OUT_WIDTH + 1);

  logic [OUT_WIDTH-1:0] r_bin;
  logic [11:0]          r_bcd;
  logic [CW-1:0]        r_cnt;
  logic [11:0]          w_adj;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < 3; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CW'(OUT_WIDTH);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[10:0], r_bin[OUT_WIDTH-1]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done     = (r_cnt == '0);
  assign o_hundreds = r_bcd[11:8];
  assign o_tens     = r_bcd[7:4];
  assign o_units    = r_bcd[3:0];

endmodule

// File: rtl/scene_draw_sequencer.sv
// Snapshots game state on frame_start, converts the score to BCD and streams
// one draw command per visible object over a registered valid/ready interface.
module scene_draw_sequencer
  import scene_draw_sequencer_pkg::*;
#(
  parameter int ADDRESSWIDTH = 16,
  parameter int OUT_WIDTH    = 8,
  parameter int DIGIT_PITCH  = 6,
  parameter int X_SCORE      = 4,
  parameter int Y_SCORE      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [OUT_WIDTH-1:0]    xcursor,
  input  logic [OUT_WIDTH-1:0]    ycursor,
  input  logic [OUT_WIDTH-1:0]    xenemy1,
  input  logic [OUT_WIDTH-1:0]    yenemy1,
  input  logic [OUT_WIDTH-1:0]    xenemy2,
  input  logic [OUT_WIDTH-1:0]    yenemy2,
  input  logic [OUT_WIDTH-1:0]    xenemy3,
  input  logic [OUT_WIDTH-1:0]    yenemy3,
  input  logic                    spawn_enemy1,
  input  logic                    spawn_enemy2,
  input  logic                    spawn_enemy3,
  input  logic [ADDRESSWIDTH-1:0] adr_enemy1,
  input  logic [ADDRESSWIDTH-1:0] adr_enemy2,
  input  logic [ADDRESSWIDTH-1:0] adr_enemy3,
  input  logic                    base1_nuked,
  input  logic                    base2_nuked,
  input  logic                    base3_nuked,
  input  logic [OUT_WIDTH-1:0]    killcount,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ADDRESSWIDTH-1:0] cmd_adr,
  output logic [OUT_WIDTH-1:0]    cmd_x,
  output logic [OUT_WIDTH-1:0]    cmd_y,
  output logic                    cmd_last,
  output logic                    busy
);

  localparam logic [OUT_WIDTH-1:0] X_DIGIT_H = OUT_WIDTH'(X_SCORE);
  localparam logic [OUT_WIDTH-1:0] X_DIGIT_T = OUT_WIDTH'(X_SCORE + DIGIT_PITCH);
  localparam logic [OUT_WIDTH-1:0] X_DIGIT_U = OUT_WIDTH'(X_SCORE + 2 * DIGIT_PITCH);
  localparam logic [OUT_WIDTH-1:0] Y_DIGIT   = OUT_WIDTH'(Y_SCORE);

  seq_state_t              r_state;
  slot_t                   r_slot;
  logic                    r_busy;
  logic                    r_cmd_valid;
  logic                    r_cmd_last;
  logic [ADDRESSWIDTH-1:0] r_cmd_adr;
  logic [OUT_WIDTH-1:0]    r_cmd_x;
  logic [OUT_WIDTH-1:0]    r_cmd_y;

  logic [OUT_WIDTH-1:0]    r_xcursor, r_ycursor;
  logic [OUT_WIDTH-1:0]    r_xenemy [3];
  logic [OUT_WIDTH-1:0]    r_yenemy [3];
  logic [ADDRESSWIDTH-1:0] r_adr_enemy [3];
  logic [2:0]              r_spawn, r_nuked;

  logic                    w_bcd_start, w_bcd_done;
  logic [3:0]              w_h, w_t, w_u;
  logic [NUM_SLOTS-1:0]    w_emit_mask;
  slot_t                   w_next_slot;
  logic [1:0]              w_enemy_idx;
  logic [ADDRESSWIDTH-1:0] w_adr;
  logic [OUT_WIDTH-1:0]    w_x, w_y;
  logic                    w_last;

  assign w_bcd_start = (r_state == IDLE) && frame_start;

  bcd_converter #(.OUT_WIDTH(OUT_WIDTH)) u_bcd (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_bcd_start),
    .i_bin     (killcount),
    .o_done    (w_bcd_done),
    .o_hundreds(w_h),
    .o_tens    (w_t),
    .o_units   (w_u)
  );

  // Leading-zero suppression: tens shows whenever any higher digit is non-zero.
  assign w_emit_mask = {1'b1, (w_h != 4'd0) || (w_t != 4'd0), (w_h != 4'd0),
                        3'b111, r_spawn, 1'b1};

  // Lowest visible slot after the current one; slot 9 is always visible.
  always_comb begin
    w_next_slot = SLOT_UNITS;
    for (int i = NUM_SLOTS - 1; i > 0; i--) begin
      if (w_emit_mask[i] && (slot_t'(i) > r_slot)) w_next_slot = slot_t'(i);
    end
    if (r_state != EMIT) w_next_slot = SLOT_CURSOR;
  end

  assign w_enemy_idx = w_next_slot[1:0] - 2'd1;
  assign w_last      = (w_next_slot == SLOT_UNITS);

  always_comb begin
    w_adr = '0;
    w_x   = '0;
    w_y   = '0;
    case (w_next_slot)
      SLOT_CURSOR: begin
        w_adr = ADDRESSWIDTH'(ADR_CURSOR);
        w_x   = r_xcursor;
        w_y   = r_ycursor;
      end
      SLOT_ENEMY1, SLOT_ENEMY2, SLOT_ENEMY3: begin
        w_adr = r_adr_enemy[w_enemy_idx];
        w_x   = r_xenemy[w_enemy_idx];
        w_y   = r_yenemy[w_enemy_idx];
      end
      SLOT_BASE1, SLOT_BASE2, SLOT_BASE3: begin
        w_adr = r_nuked[w_next_slot[1:0]] ? ADDRESSWIDTH'(ADR_BASE_NUKED)
                                          : ADDRESSWIDTH'(ADR_BASE_OK);
        w_x   = OUT_WIDTH'(x_base(w_next_slot[1:0]));
        w_y   = OUT_WIDTH'(Y_BASE);
      end
      SLOT_HUND: begin
        w_adr = ADDRESSWIDTH'(digit_offset(w_h));
        w_x   = X_DIGIT_H;
        w_y   = Y_DIGIT;
      end
      SLOT_TENS: begin
        w_adr = ADDRESSWIDTH'(digit_offset(w_t));
        w_x   = X_DIGIT_T;
        w_y   = Y_DIGIT;
      end
      SLOT_UNITS: begin
        w_adr = ADDRESSWIDTH'(digit_offset(w_u));
        w_x   = X_DIGIT_U;
        w_y   = Y_DIGIT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_slot      <= SLOT_CURSOR;
      r_busy      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_last  <= 1'b0;
      r_cmd_adr   <= '0;
      r_cmd_x     <= '0;
      r_cmd_y     <= '0;
      r_xcursor   <= '0;
      r_ycursor   <= '0;
      r_spawn     <= '0;
      r_nuked     <= '0;
      for (int i = 0; i < 3; i++) begin
        r_xenemy[i]    <= '0;
        r_yenemy[i]    <= '0;
        r_adr_enemy[i] <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_xcursor      <= xcursor;
            r_ycursor      <= ycursor;
            r_xenemy       <= '{xenemy1, xenemy2, xenemy3};
            r_yenemy       <= '{yenemy1, yenemy2, yenemy3};
            r_adr_enemy    <= '{adr_enemy1, adr_enemy2, adr_enemy3};
            r_spawn        <= {spawn_enemy3, spawn_enemy2, spawn_enemy1};
            r_nuked        <= {base3_nuked, base2_nuked, base1_nuked};
            r_slot         <= SLOT_CURSOR;
            r_busy         <= 1'b1;
            r_state        <= CONVERT;
          end
        end
        CONVERT: begin
          if (w_bcd_done) begin
            r_slot      <= w_next_slot;
            r_cmd_valid <= 1'b1;
            r_cmd_adr   <= w_adr;
            r_cmd_x     <= w_x;
            r_cmd_y     <= w_y;
            r_cmd_last  <= w_last;
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          if (r_cmd_valid && cmd_ready) begin
            if (r_cmd_last) begin
              r_cmd_valid <= 1'b0;
              r_cmd_last  <= 1'b0;
              r_cmd_adr   <= '0;
              r_cmd_x     <= '0;
              r_cmd_y     <= '0;
              r_slot      <= SLOT_CURSOR;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_slot     <= w_next_slot;
              r_cmd_adr  <= w_adr;
              r_cmd_x    <= w_x;
              r_cmd_y    <= w_y;
              r_cmd_last <= w_last;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_adr   = r_cmd_adr;
  assign cmd_x     = r_cmd_x;
  assign cmd_y     = r_cmd_y;
  assign cmd_last  = r_cmd_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_scene_draw_sequencer.sv
// Directed bench for scene_draw_sequencer: each scenario task drives a frame,
// captures the transfers and compares them against hand-computed command lists.
module tb_scene_draw_sequencer;

  localparam int AW = 16;
  localparam int OW = 8;
  typedef logic [AW+2*OW:0] ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [OW-1:0] xcursor, ycursor;
  logic [OW-1:0] xenemy1, yenemy1, xenemy2, yenemy2, xenemy3, yenemy3;
  logic          spawn_enemy1, spawn_enemy2, spawn_enemy3;
  logic [AW-1:0] adr_enemy1, adr_enemy2, adr_enemy3;
  logic          base1_nuked, base2_nuked, base3_nuked;
  logic [OW-1:0] killcount;
  logic          cmd_valid, cmd_ready, cmd_last, busy;
  logic [AW-1:0] cmd_adr;
  logic [OW-1:0] cmd_x, cmd_y;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t got [16];
  ent_t exp_q [$];

  scene_draw_sequencer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .xcursor(xcursor), .ycursor(ycursor),
    .xenemy1(xenemy1), .yenemy1(yenemy1),
    .xenemy2(xenemy2), .yenemy2(yenemy2),
    .xenemy3(xenemy3), .yenemy3(yenemy3),
    .spawn_enemy1(spawn_enemy1), .spawn_enemy2(spawn_enemy2), .spawn_enemy3(spawn_enemy3),
    .adr_enemy1(adr_enemy1), .adr_enemy2(adr_enemy2), .adr_enemy3(adr_enemy3),
    .base1_nuked(base1_nuked), .base2_nuked(base2_nuked), .base3_nuked(base3_nuked),
    .killcount(killcount),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_last(cmd_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic ent_t ent(input int adr, input int x, input int y, input bit last);
    return {AW'(adr), OW'(x), OW'(y), last};
  endfunction

  task automatic set_a(input int kc);
    xcursor = 10;  ycursor = 20;
    xenemy1 = 30;  yenemy1 = 31;  adr_enemy1 = 16'h1000;
    xenemy2 = 50;  yenemy2 = 51;  adr_enemy2 = 16'h2000;
    xenemy3 = 70;  yenemy3 = 71;  adr_enemy3 = 16'h3000;
    {spawn_enemy1, spawn_enemy2, spawn_enemy3} = 3'b111;
    {base1_nuked, base2_nuked, base3_nuked}    = 3'b000;
    killcount = OW'(kc);
  endtask

  task automatic set_b(input int kc);
    xcursor = 100; ycursor = 200;
    xenemy1 = 11;  yenemy1 = 12;  adr_enemy1 = 16'h1111;
    xenemy2 = 60;  yenemy2 = 61;  adr_enemy2 = 16'h2000;
    xenemy3 = 90;  yenemy3 = 91;  adr_enemy3 = 16'h3333;
    {spawn_enemy1, spawn_enemy2, spawn_enemy3} = 3'b010;
    {base1_nuked, base2_nuked, base3_nuked}    = 3'b001;
    killcount = OW'(kc);
  endtask

  // Objects of setting A: cursor, three enemies, three intact bases.
  task automatic push_a_objects();
    exp_q = '{};
    exp_q.push_back(ent('h0100, 10, 20, 0));
    exp_q.push_back(ent('h1000, 30, 31, 0));
    exp_q.push_back(ent('h2000, 50, 51, 0));
    exp_q.push_back(ent('h3000, 70, 71, 0));
    exp_q.push_back(ent('h0200, 48, 232, 0));
    exp_q.push_back(ent('h0200, 128, 232, 0));
    exp_q.push_back(ent('h0200, 208, 232, 0));
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Drives cmd_ready and records every transfer until cmd_last is accepted.
  task automatic collect_frame(input bit rnd, input int pulse_at, output int n,
                               output int lat, output int bubbles, output int stall_bad,
                               output bit timed_out);
    bit   seen, done, stalled;
    ent_t held;
    n = 0; lat = 0; bubbles = 0; stall_bad = 0; timed_out = 1'b1;
    seen = 1'b0; done = 1'b0; stalled = 1'b0; held = '0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (stalled && (cmd_valid !== 1'b1 || {cmd_adr, cmd_x, cmd_y, cmd_last} !== held))
        stall_bad++;
      cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cmd_valid === 1'b1) begin
        if (!seen) lat = cyc;
        seen = 1'b1;
        if (cmd_ready) begin
          if (n == pulse_at) frame_start = 1'b1;
          if (n < 16) got[n] = {cmd_adr, cmd_x, cmd_y, cmd_last};
          n++;
          if (cmd_last === 1'b1) begin
            done = 1'b1;
            timed_out = 1'b0;
          end
        end
      end else if (seen) begin
        bubbles++;
      end
      stalled = (cmd_valid === 1'b1) && !cmd_ready;
      held = {cmd_adr, cmd_x, cmd_y, cmd_last};
    end
    @(negedge clk);
    frame_start = 1'b0;
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frame_start = 1'b0;
    cmd_ready = 1'b0;
    set_a(0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_valid, cmd_last, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got v/l/b=%b expected 000", {cmd_valid, cmd_last, busy});
    end
    n_checks++;
    if ({cmd_adr, cmd_x, cmd_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {cmd_adr, cmd_x, cmd_y});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_visible();
    int n, lat, bub, sb; bit to;
    set_a(0);
    push_a_objects();
    exp_q.push_back(ent('h0400, 16, 4, 1));
    start_frame();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL all_visible busy_start: got %b expected 1", busy); end
    collect_frame(1'b0, -1, n, lat, bub, sb, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL all_visible timeout: got %0d transfers", n); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL all_visible latency: got %0d expected 9", lat); end
    n_checks++;
    if (bub !== 0) begin n_fail++; $display("FAIL all_visible bubbles: got %0d expected 0", bub); end
    n_checks++;
    if (n !== exp_q.size()) begin n_fail++; $display("FAIL all_visible count: got %0d expected %0d", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL all_visible cmd%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    n_checks++;
    if ({busy, cmd_valid} !== 2'b00) begin n_fail++; $display("FAIL all_visible end_idle: got busy/valid=%b expected 00", {busy, cmd_valid}); end
  endtask

  // Also pulses frame_start on the cmd_last transfer edge, which must be ignored.
  task automatic test_mixed();
    int n, lat, bub, sb; bit to;
    set_b(137);
    exp_q = '{};
    exp_q.push_back(ent('h0100, 100, 200, 0));
    exp_q.push_back(ent('h2000, 60, 61, 0));
    exp_q.push_back(ent('h0200, 48, 232, 0));
    exp_q.push_back(ent('h0200, 128, 232, 0));
    exp_q.push_back(ent('h0240, 208, 232, 0));
    exp_q.push_back(ent('h0440, 4, 4, 0));
    exp_q.push_back(ent('h04C0, 10, 4, 0));
    exp_q.push_back(ent('h05C0, 16, 4, 1));
    start_frame();
    collect_frame(1'b0, 7, n, lat, bub, sb, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL mixed timeout: got %0d transfers", n); end
    n_checks++;
    if (n !== exp_q.size()) begin n_fail++; $display("FAIL mixed count: got %0d expected %0d", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL mixed cmd%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if ({busy, cmd_valid} !== 2'b00) begin n_fail++; $display("FAIL mixed last_edge_start: got busy/valid=%b expected 00", {busy, cmd_valid}); end
  endtask

  task automatic test_suppress();
    int n, lat, bub, sb; bit to;
    ent_t u5;
    set_a(5);
    push_a_objects();
    exp_q.push_back(ent('h0540, 16, 4, 1));
    start_frame();
    collect_frame(1'b0, -1, n, lat, bub, sb, to);
    n_checks++;
    if (to || n !== exp_q.size()) begin n_fail++; $display("FAIL kc5 count: got %0d expected %0d", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL kc5 cmd%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    u5 = (n > 0 && n <= 16) ? got[n-1] : '0;

    set_a(40);
    push_a_objects();
    exp_q.push_back(ent('h0500, 10, 4, 0));
    exp_q.push_back(ent('h0400, 16, 4, 1));
    start_frame();
    collect_frame(1'b0, -1, n, lat, bub, sb, to);
    n_checks++;
    if (to || n !== exp_q.size()) begin n_fail++; $display("FAIL kc40 count: got %0d expected %0d", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL kc40 cmd%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    n_checks++;
    if (n > 0 && n <= 16 && got[n-1][2*OW:OW+1] !== u5[2*OW:OW+1]) begin
      n_fail++;
      $display("FAIL units_x_fixed: got %0d expected %0d", got[n-1][2*OW:OW+1], u5[2*OW:OW+1]);
    end
  endtask

  task automatic test_backpressure();
    int n, lat, bub, sb; bit to;
    set_b(137);
    exp_q = '{};
    exp_q.push_back(ent('h0100, 100, 200, 0));
    exp_q.push_back(ent('h2000, 60, 61, 0));
    exp_q.push_back(ent('h0200, 48, 232, 0));
    exp_q.push_back(ent('h0200, 128, 232, 0));
    exp_q.push_back(ent('h0240, 208, 232, 0));
    exp_q.push_back(ent('h0440, 4, 4, 0));
    exp_q.push_back(ent('h04C0, 10, 4, 0));
    exp_q.push_back(ent('h05C0, 16, 4, 1));
    start_frame();
    collect_frame(1'b1, -1, n, lat, bub, sb, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL backpressure timeout: got %0d transfers", n); end
    n_checks++;
    if (sb !== 0) begin n_fail++; $display("FAIL backpressure stable: got %0d changes while stalled expected 0", sb); end
    n_checks++;
    if (n !== exp_q.size()) begin n_fail++; $display("FAIL backpressure count: got %0d expected %0d", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL backpressure cmd%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_snapshot();
    int n, lat, bub, sb; bit to;
    bit stray;
    set_a(250);
    push_a_objects();
    exp_q.push_back(ent('h0480, 4, 4, 0));
    exp_q.push_back(ent('h0540, 10, 4, 0));
    exp_q.push_back(ent('h0400, 16, 4, 1));
    start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    set_b(5);
    @(negedge clk);
    frame_start = 1'b0;
    collect_frame(1'b0, 2, n, lat, bub, sb, to);
    n_checks++;
    if (to || n !== exp_q.size()) begin n_fail++; $display("FAIL snapshot count: got %0d expected %0d", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL snapshot cmd%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    stray = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || cmd_valid !== 1'b0) stray = 1'b1;
    end
    n_checks++;
    if (stray) begin n_fail++; $display("FAIL snapshot no_queue: got activity after frame expected idle"); end
  endtask

  task automatic test_reset_mid_frame();
    int n, lat, bub, sb; bit to;
    int xfers;
    bit saw_last;
    set_a(0);
    start_frame();
    xfers = 0;
    saw_last = 1'b0;
    cmd_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && xfers < 3; cyc++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
        xfers++;
        if (cmd_last === 1'b1) saw_last = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    cmd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (xfers !== 3 || saw_last) begin n_fail++; $display("FAIL abort_pre: got %0d transfers last=%b expected 3 last=0", xfers, saw_last); end
    n_checks++;
    if ({cmd_valid, cmd_last, busy, cmd_adr, cmd_x, cmd_y} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got v/l/b=%b data=%h expected all 0", {cmd_valid, cmd_last, busy}, {cmd_adr, cmd_x, cmd_y});
    end
    rst = 1'b0;
    push_a_objects();
    exp_q.push_back(ent('h0400, 16, 4, 1));
    start_frame();
    collect_frame(1'b0, -1, n, lat, bub, sb, to);
    n_checks++;
    if (to || n !== exp_q.size()) begin n_fail++; $display("FAIL after_abort count: got %0d expected %0d", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL after_abort cmd%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_all_visible();
    test_mixed();
    test_suppress();
    test_backpressure();
    test_snapshot();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
